// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run controller.
//   run_state_t : controller state encoding
//   CNT_W_DEF   : default width of the run statistics counters
//   sat_inc     : increment that sticks at the all-ones value of a given width (width <= 32)
package run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, RUN, DRAIN, DONE_S} run_state_t;

  localparam int unsigned CNT_W_DEF = 16;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   clr : synchronous clear, wins over en
//   en  : increment enable
//   q   : count, sticks at all-ones (W <= 32)
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= W'(sat_inc(32'(q), W));
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Responder side of the START/DONE run handshake: holds the core idle while START is
// high, launches on START falling, drains the pipeline after halt, then raises DONE.
// Optional watchdog: define RUN_WATCHDOG_EN to end runs of WDOG_LIMIT cycles with timeout_o.
//   CLK, RESET  : clock, synchronous active-high reset
//   START       : high = hold/arm, falling = launch, high in RUN/DRAIN = abort
//   halt_i      : decoded halt, honoured only in RUN
//   instr_vld_i : instruction retired this cycle
//   pc_rst_o, run_en_o, wb_en_o : core control (registered)
//   DONE, timeout_o             : run complete / run ended by watchdog (registered)
//   cycle_count, instr_count    : saturating statistics of the current or last run
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT   = 4096
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             halt_i,
  input  logic             instr_vld_i,
  output logic             pc_rst_o,
  output logic             run_en_o,
  output logic             wb_en_o,
  output logic             DONE,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  run_state_t         state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               pc_rst_d, run_en_d, wb_en_d, done_d;
  logic               wdog_hit_c;
  logic               cnt_clr_c;

`ifdef RUN_WATCHDOG_EN
  // True on the RUN cycle that brings cycle_count up to the limit.
  assign wdog_hit_c = (32'(cycle_count) + 32'd1) >= 32'(WDOG_LIMIT);
`else
  logic unused_wdog;
  assign wdog_hit_c  = 1'b0;
  assign unused_wdog = (WDOG_LIMIT == 0);
`endif

  // Next state, drain counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:   if (START) state_d = ARMED;
      ARMED:  if (!START) state_d = RUN;
      RUN: begin
        if (START) begin
          state_d = ARMED;
        end else if (halt_i) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = DONE_S;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end else if (wdog_hit_c) begin
          state_d = DONE_S;
        end
      end
      DRAIN: begin
        if (START) begin
          state_d = ARMED;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
          if (drain_q <= DRAIN_W'(1)) state_d = DONE_S;
        end
      end
      DONE_S: if (START) state_d = ARMED;
      default: state_d = IDLE;
    endcase
    // Outputs follow the state being entered so they are valid right after the edge.
    pc_rst_d = (state_d == IDLE) || (state_d == ARMED);
    run_en_d = (state_d == RUN);
    wb_en_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d   = (state_d == DONE_S);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      pc_rst_o <= 1'b1;
      run_en_o <= 1'b0;
      wb_en_o  <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      pc_rst_o <= pc_rst_d;
      run_en_o <= run_en_d;
      wb_en_o  <= wb_en_d;
      DONE     <= done_d;
    end
  end

`ifdef RUN_WATCHDOG_EN
  // Leaving RUN for DONE_S without a halt can only be the watchdog.
  logic timeout_d;
  always_comb begin
    timeout_d = timeout_o;
    if (state_d == ARMED) begin
      timeout_d = 1'b0;
    end else if ((state_q == RUN) && (state_d == DONE_S) && !halt_i) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) timeout_o <= 1'b0;
    else       timeout_o <= timeout_d;
  end
`else
  assign timeout_o = 1'b0;
`endif

  // Statistics clear whenever ARMED is being entered or held.
  assign cnt_clr_c = (state_d == ARMED);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr (cnt_clr_c),
    .en  (state_q == RUN),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr (cnt_clr_c),
    .en  ((state_q == RUN) && instr_vld_i),
    .q   (instr_count)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: three instances (default, 4-bit/no-drain, watchdog limit 8).
module tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start [3];
  logic halt  [3];
  logic vld   [3];
  logic pc_rst [3];
  logic run_en [3];
  logic wb_en  [3];
  logic done   [3];
  logic tmo    [3];
  logic [15:0] cc0, ic0, cc2, ic2;
  logic [3:0]  cc1, ic1;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] O_IDLE  = 5'b10000;
  localparam logic [4:0] O_RUN   = 5'b01100;
  localparam logic [4:0] O_DRAIN = 5'b00100;
  localparam logic [4:0] O_DONE  = 5'b00010;
  localparam logic [4:0] O_TMO   = 5'b00011;

  run_ctrl #(.CNT_W(16), .DRAIN_CYCLES(2), .WDOG_LIMIT(4096)) dut0 (
    .CLK(clk), .RESET(rst), .START(start[0]), .halt_i(halt[0]), .instr_vld_i(vld[0]),
    .pc_rst_o(pc_rst[0]), .run_en_o(run_en[0]), .wb_en_o(wb_en[0]), .DONE(done[0]),
    .timeout_o(tmo[0]), .cycle_count(cc0), .instr_count(ic0));

  run_ctrl #(.CNT_W(4), .DRAIN_CYCLES(0), .WDOG_LIMIT(4096)) dut1 (
    .CLK(clk), .RESET(rst), .START(start[1]), .halt_i(halt[1]), .instr_vld_i(vld[1]),
    .pc_rst_o(pc_rst[1]), .run_en_o(run_en[1]), .wb_en_o(wb_en[1]), .DONE(done[1]),
    .timeout_o(tmo[1]), .cycle_count(cc1), .instr_count(ic1));

  run_ctrl #(.CNT_W(16), .DRAIN_CYCLES(2), .WDOG_LIMIT(8)) dut2 (
    .CLK(clk), .RESET(rst), .START(start[2]), .halt_i(halt[2]), .instr_vld_i(vld[2]),
    .pc_rst_o(pc_rst[2]), .run_en_o(run_en[2]), .wb_en_o(wb_en[2]), .DONE(done[2]),
    .timeout_o(tmo[2]), .cycle_count(cc2), .instr_count(ic2));

  function automatic logic [4:0] outs(input int i);
    return {pc_rst[i], run_en[i], wb_en[i], done[i], tmo[i]};
  endfunction

  function automatic int get_cc(input int i);
    if (i == 0) return int'(cc0);
    if (i == 1) return int'(cc1);
    return int'(cc2);
  endfunction

  function automatic int get_ic(input int i);
    if (i == 0) return int'(ic0);
    if (i == 1) return int'(ic1);
    return int'(ic2);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One run: 2 cycles of START, launch, halt on RUN cycle n, drain d cycles, DONE.
  // abort_at > 0 raises START together with halt on that RUN cycle and returns with START high.
  task automatic do_run(input int i, input int n, input int d, input int cmax,
                        input int abort_at, input bit vld_all);
    int exp_ic, run_hi, wb_hi, v, done_at, ecc, eic;
    logic [4:0] ev;
    start[i] = 1'b1;
    halt[i]  = 1'($urandom_range(0, 1));
    vld[i]   = 1'($urandom_range(0, 1));
    step;
    step;
    checks++;
    if (outs(i) !== O_IDLE || get_cc(i) != 0 || get_ic(i) != 0) begin
      failures++;
      $display("FAIL armed dut%0d outs=%b cc=%0d ic=%0d expected outs=%b cc=0 ic=0",
               i, outs(i), get_cc(i), get_ic(i), O_IDLE);
    end
    start[i] = 1'b0;
    halt[i]  = 1'b0;
    vld[i]   = 1'($urandom_range(0, 1));
    step;
    checks++;
    if (outs(i) !== O_RUN || get_cc(i) != 0) begin
      failures++;
      $display("FAIL launch dut%0d outs=%b cc=%0d expected outs=%b cc=0", i, outs(i), get_cc(i), O_RUN);
    end
    exp_ic = 0;
    run_hi = (run_en[i] === 1'b1) ? 1 : 0;
    wb_hi  = (wb_en[i] === 1'b1) ? 1 : 0;
    for (int k = 1; k <= n; k++) begin
      v = vld_all ? 1 : int'($urandom_range(0, 1));
      vld[i]  = 1'(v);
      halt[i] = (k == n);
      if (k == abort_at) begin
        start[i] = 1'b1;
        halt[i]  = 1'b1;
      end
      step;
      if (k == abort_at) begin
        checks++;
        if (outs(i) !== O_IDLE || get_cc(i) != 0 || get_ic(i) != 0) begin
          failures++;
          $display("FAIL abort dut%0d outs=%b cc=%0d ic=%0d expected outs=%b cc=0 ic=0",
                   i, outs(i), get_cc(i), get_ic(i), O_IDLE);
        end
        halt[i] = 1'b0;
        vld[i]  = 1'b0;
        repeat (3) begin
          step;
          checks++;
          if (done[i] !== 1'b0 || run_en[i] !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold dut%0d done=%b run_en=%b expected 0 0", i, done[i], run_en[i]);
          end
        end
        return;
      end
      exp_ic += v;
      ev = (k < n) ? O_RUN : ((d > 0) ? O_DRAIN : O_DONE);
      checks++;
      if (outs(i) !== ev || get_cc(i) != imin(k, cmax) || get_ic(i) != imin(exp_ic, cmax)) begin
        failures++;
        $display("FAIL run dut%0d k=%0d outs=%b cc=%0d ic=%0d expected outs=%b cc=%0d ic=%0d",
                 i, k, outs(i), get_cc(i), get_ic(i), ev, imin(k, cmax), imin(exp_ic, cmax));
      end
      if (run_en[i] === 1'b1) run_hi++;
      if (wb_en[i] === 1'b1) wb_hi++;
    end
    ecc = imin(n, cmax);
    eic = imin(exp_ic, cmax);
    done_at = (done[i] === 1'b1) ? 1 : 0;
    for (int j = 1; j <= d; j++) begin
      halt[i] = 1'($urandom_range(0, 1));
      vld[i]  = 1'($urandom_range(0, 1));
      step;
      ev = (j < d) ? O_DRAIN : O_DONE;
      checks++;
      if (outs(i) !== ev || get_cc(i) != ecc || get_ic(i) != eic) begin
        failures++;
        $display("FAIL drain dut%0d j=%0d outs=%b cc=%0d ic=%0d expected outs=%b cc=%0d ic=%0d",
                 i, j, outs(i), get_cc(i), get_ic(i), ev, ecc, eic);
      end
      if (run_en[i] === 1'b1) run_hi++;
      if (wb_en[i] === 1'b1) wb_hi++;
      if (done[i] === 1'b1 && done_at == 0) done_at = j + 1;
    end
    checks++;
    if (run_hi != n) begin
      failures++;
      $display("FAIL run_en_len dut%0d got=%0d expected=%0d", i, run_hi, n);
    end
    checks++;
    if (wb_hi != n + d) begin
      failures++;
      $display("FAIL wb_en_len dut%0d got=%0d expected=%0d", i, wb_hi, n + d);
    end
    checks++;
    if (done_at != d + 1) begin
      failures++;
      $display("FAIL done_delay dut%0d got=%0d expected=%0d", i, done_at, d + 1);
    end
    repeat (2) begin
      halt[i] = 1'($urandom_range(0, 1));
      vld[i]  = 1'($urandom_range(0, 1));
      step;
      checks++;
      if (outs(i) !== O_DONE || get_cc(i) != ecc || get_ic(i) != eic) begin
        failures++;
        $display("FAIL done_hold dut%0d outs=%b cc=%0d ic=%0d expected outs=%b cc=%0d ic=%0d",
                 i, outs(i), get_cc(i), get_ic(i), O_DONE, ecc, eic);
      end
    end
    halt[i] = 1'b0;
    vld[i]  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) begin
      for (int i = 0; i < 3; i++) begin
        start[i] = 1'($urandom_range(0, 1));
        halt[i]  = 1'($urandom_range(0, 1));
        vld[i]   = 1'($urandom_range(0, 1));
      end
      step;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs(i) !== O_IDLE || get_cc(i) != 0 || get_ic(i) != 0) begin
        failures++;
        $display("FAIL reset dut%0d outs=%b cc=%0d ic=%0d expected outs=%b cc=0 ic=0",
                 i, outs(i), get_cc(i), get_ic(i), O_IDLE);
      end
      start[i] = 1'b0;
      halt[i]  = 1'b0;
      vld[i]   = 1'b0;
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_basic_run;
    do_run(0, 10, 2, 65535, 0, 1'b1);
    do_run(0, $urandom_range(1, 30), 2, 65535, 0, 1'b0);
  endtask

  task automatic test_restart;
    start[0] = 1'b1;
    step;
    checks++;
    if (outs(0) !== O_IDLE || get_cc(0) != 0 || get_ic(0) != 0) begin
      failures++;
      $display("FAIL restart outs=%b cc=%0d ic=%0d expected outs=%b cc=0 ic=0",
               outs(0), get_cc(0), get_ic(0), O_IDLE);
    end
    repeat (40) begin
      halt[0] = 1'($urandom_range(0, 1));
      step;
    end
    checks++;
    if (outs(0) !== O_IDLE) begin
      failures++;
      $display("FAIL armed_wait outs=%b expected %b", outs(0), O_IDLE);
    end
    halt[0] = 1'b0;
    do_run(0, $urandom_range(1, 20), 2, 65535, 0, 1'b0);
  endtask

  task automatic test_abort;
    do_run(0, 10, 2, 65535, 4, 1'b1);
    do_run(0, $urandom_range(5, 25), 2, 65535, $urandom_range(1, 4), 1'b0);
    // Abort from DRAIN
    start[0] = 1'b1;
    step;
    start[0] = 1'b0;
    step;
    halt[0] = 1'b1;
    vld[0]  = 1'b1;
    step;
    halt[0]  = 1'b0;
    start[0] = 1'b1;
    step;
    checks++;
    if (outs(0) !== O_IDLE || get_cc(0) != 0 || get_ic(0) != 0) begin
      failures++;
      $display("FAIL drain_abort outs=%b cc=%0d ic=%0d expected outs=%b cc=0 ic=0",
               outs(0), get_cc(0), get_ic(0), O_IDLE);
    end
    vld[0] = 1'b0;
    do_run(0, $urandom_range(1, 20), 2, 65535, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 5; r++) do_run(0, $urandom_range(1, 40), 2, 65535, 0, 1'b0);
  endtask

  task automatic test_saturation;
    do_run(1, 20, 0, 15, 0, 1'b1);
    do_run(1, $urandom_range(1, 40), 0, 15, 0, 1'b0);
    do_run(1, 1, 0, 15, 0, 1'b0);
  endtask

  task automatic test_watchdog;
    start[2] = 1'b1;
    step;
    start[2] = 1'b0;
    halt[2]  = 1'b0;
    vld[2]   = 1'b1;
    step;
`ifdef RUN_WATCHDOG_EN
    for (int k = 1; k <= 8; k++) begin
      step;
      checks++;
      if (outs(2) !== ((k < 8) ? O_RUN : O_TMO) || get_cc(2) != k) begin
        failures++;
        $display("FAIL wdog k=%0d outs=%b cc=%0d expected outs=%b cc=%0d",
                 k, outs(2), get_cc(2), (k < 8) ? O_RUN : O_TMO, k);
      end
    end
    start[2] = 1'b1;
    step;
    checks++;
    if (outs(2) !== O_IDLE) begin
      failures++;
      $display("FAIL wdog_clear outs=%b expected %b", outs(2), O_IDLE);
    end
    start[2] = 1'b0;
    step;
    for (int k = 1; k <= 8; k++) begin
      halt[2] = (k == 8);
      step;
      checks++;
      if (outs(2) !== ((k < 8) ? O_RUN : O_DRAIN)) begin
        failures++;
        $display("FAIL wdog_halt k=%0d outs=%b expected %b", k, outs(2), (k < 8) ? O_RUN : O_DRAIN);
      end
    end
    halt[2] = 1'b0;
    step;
    step;
    checks++;
    if (outs(2) !== O_DONE || get_cc(2) != 8) begin
      failures++;
      $display("FAIL wdog_halt_done outs=%b cc=%0d expected outs=%b cc=8", outs(2), get_cc(2), O_DONE);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      step;
      checks++;
      if (outs(2) !== O_RUN || get_cc(2) != k) begin
        failures++;
        $display("FAIL no_wdog k=%0d outs=%b cc=%0d expected outs=%b cc=%0d", k, outs(2), get_cc(2), O_RUN, k);
      end
    end
    start[2] = 1'b1;
    step;
    checks++;
    if (outs(2) !== O_IDLE) begin
      failures++;
      $display("FAIL no_wdog_abort outs=%b expected %b", outs(2), O_IDLE);
    end
`endif
    vld[2] = 1'b0;
  endtask

  task automatic test_reset_midrun;
    start[0] = 1'b1;
    step;
    start[0] = 1'b0;
    vld[0]   = 1'b1;
    repeat (4) step;
    rst = 1'b1;
    step;
    checks++;
    if (outs(0) !== O_IDLE || get_cc(0) != 0 || get_ic(0) != 0) begin
      failures++;
      $display("FAIL reset_midrun outs=%b cc=%0d ic=%0d expected outs=%b cc=0 ic=0",
               outs(0), get_cc(0), get_ic(0), O_IDLE);
    end
    rst    = 1'b0;
    vld[0] = 1'b0;
    step;
    checks++;
    if (outs(0) !== O_IDLE) begin
      failures++;
      $display("FAIL idle_after_reset outs=%b expected %b", outs(0), O_IDLE);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      halt[i]  = 1'b0;
      vld[i]   = 1'b0;
    end
    test_reset;
    test_basic_run;
    test_restart;
    test_abort;
    test_back_to_back;
    test_saturation;
    test_watchdog;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
